dpram_be: RTL

DPRAM_BE -- requirements
Module: dpram_be

---
 rtl/dpram_be.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dpram_be.sv
// True dual-port RAM with byte enables, write-through read data, same-address write arbitration
// (port A wins), and a post-reset zero-fill sequence.
module dpram_be #(
  parameter int unsigned DATA     = 8,
  parameter int unsigned ADDR     = 14,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned CLEAR_EN = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                busy,

  input  logic                a_ce,
  input  logic                a_wr,
  input  logic [DATA/8-1:0]   a_be,
  input  logic [ADDR-1:0]     a_addr,
  input  logic [DATA-1:0]     a_din,
  output logic [DATA-1:0]     a_dout,
  output logic                a_valid,

  input  logic                b_ce,
  input  logic                b_wr,
  input  logic [DATA/8-1:0]   b_be,
  input  logic [ADDR-1:0]     b_addr,
  input  logic [DATA-1:0]     b_din,
  output logic [DATA-1:0]     b_dout,
  output logic                b_valid,

  output logic                collision
);

  localparam int unsigned NumBytes = DATA / 8;
  localparam int unsigned Depth    = 2 ** ADDR;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR-1:0]   cnt_q, cnt_d;
  logic [DATA-1:0]   mem [Depth];

  logic              clearing;
  logic              clr_we;
  logic              a_acc, b_acc, a_we, b_we, same_we;
  logic [DATA-1:0]   a_word, b_word;

  logic [DATA-1:0]   a_q, b_q;
  logic              a_vq, b_vq, coll_q;

  assign clearing = (state_q == StClear);
  // Reset itself also counts as busy so accesses are never accepted under reset.
  assign busy     = clearing | ~reset_n;
  assign clr_we   = clearing & reset_n & (CLEAR_EN != 0);

  assign a_acc   = a_ce & ~busy;
  assign b_acc   = b_ce & ~busy;
  assign a_we    = a_acc & a_wr;
  assign b_we    = b_acc & b_wr;
  assign same_we = a_we & b_we & (a_addr == b_addr);

  // Clear FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        if (CLEAR_EN != 0) begin
          cnt_d = cnt_q + ADDR'(1);
          if (cnt_q == {ADDR{1'b1}}) begin
            state_d = StReady;
          end
        end else begin
          state_d = StReady;
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Final stored word per port: a reading port sees the old word, a writing port sees the
  // merged result including the other port's bytes when both hit the same address.
  always_comb begin
    a_word = mem[a_addr];
    b_word = mem[b_addr];
    for (int i = 0; i < NumBytes; i++) begin
      if (a_we && a_be[i]) begin
        a_word[8*i +: 8] = a_din[8*i +: 8];
      end else if (same_we && b_be[i]) begin
        a_word[8*i +: 8] = b_din[8*i +: 8];
      end
      if (same_we && a_be[i]) begin
        b_word[8*i +: 8] = a_din[8*i +: 8];
      end else if (b_we && b_be[i]) begin
        b_word[8*i +: 8] = b_din[8*i +: 8];
      end
    end
  end

  // Port A writes last so its bytes take precedence on an address clash.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NumBytes; i++) begin
        if (b_we && b_be[i]) begin
          mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
        end
        if (a_we && a_be[i]) begin
          mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      a_vq   <= 1'b0;
      b_vq   <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      a_vq   <= a_acc;
      b_vq   <= b_acc;
      coll_q <= same_we;
      if (a_acc) begin
        a_q <= a_word;
      end
      if (b_acc) begin
        b_q <= b_word;
      end
    end
  end

  assign collision = coll_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA-1:0] a_q2, b_q2;
    logic            a_v2, b_v2;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        a_q2 <= '0;
        b_q2 <= '0;
        a_v2 <= 1'b0;
        b_v2 <= 1'b0;
      end else begin
        a_v2 <= a_vq;
        b_v2 <= b_vq;
        if (a_vq) begin
          a_q2 <= a_q;
        end
        if (b_vq) begin
          b_q2 <= b_q;
        end
      end
    end

    assign a_dout  = a_q2;
    assign b_dout  = b_q2;
    assign a_valid = a_v2;
    assign b_valid = b_v2;
  end else begin : g_out_direct
    assign a_dout  = a_q;
    assign b_dout  = b_q;
    assign a_valid = a_vq;
    assign b_valid = b_vq;
  end

endmodule
